// File: rtl/zmips_pkg.sv
// zmips_pkg: shared widths, word type and GPR writability rule for the zmips core.
`default_nettype none

package zmips_pkg;

   localparam int ZMIPS_XLEN  = 32;
   localparam int ZMIPS_NREGS = 30;

   typedef logic [ZMIPS_XLEN-1:0] zmips_word_t;

   // True for addresses that map to a real, writable GPR (r0 excluded when hard-wired to zero).
   function automatic logic zmips_gpr_writable(input int unsigned addr,
                                               input int unsigned nregs,
                                               input logic        zero_r0);
      return (addr < nregs) && !(zero_r0 && (addr == 0));
   endfunction

endpackage

`default_nettype wire

// File: rtl/zmips_regfile_rdport.sv
// zmips_regfile_rdport: one read port - address decode, special-register mux, bypass and busy mask.
`default_nettype none

module zmips_regfile_rdport
   import zmips_pkg::*;
#(
   parameter int W       = ZMIPS_XLEN,
   parameter int NREGS   = ZMIPS_NREGS,
   parameter int AW      = $clog2(NREGS + 2),
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic [AW-1:0]   addr_i,
   input  logic [W-1:0]    gpr_data_i,
   input  logic            gpr_busy_i,
   input  logic [W-1:0]    pc_reg_i,
   input  logic [W-1:0]    pc_val_i,
   input  logic            pc_wr_i,
   input  logic [1:0]      wr_en_i,
   input  logic [2*AW-1:0] wr_addr_i,
   input  logic [2*W-1:0]  wr_data_i,
   output logic [W-1:0]    data_o,
   output logic            busy_o
);

   localparam logic [AW-1:0] c_PCR = AW'(NREGS);
   localparam logic [AW-1:0] c_PCL = AW'(NREGS + 1);

   logic          w_writable;
   logic [1:0]    w_hit;
   logic [W-1:0]  w_base;

   assign w_writable = zmips_gpr_writable(32'(addr_i), NREGS, ZERO_R0);

   // A lane can only hit when its address is writable, which equals our own address here.
   always_comb begin
      w_hit = '0;
      for (int j = 0; j < 2; j++) begin
         w_hit[j] = BYPASS && w_writable && wr_en_i[j] && (wr_addr_i[j*AW +: AW] == addr_i);
      end
   end

   always_comb begin
      w_base = '0;
      if (w_writable) begin
         w_base = gpr_data_i;
      end else if (addr_i == c_PCR) begin
         w_base = (BYPASS && pc_wr_i) ? pc_val_i : pc_reg_i;
      end else if (addr_i == c_PCL) begin
         w_base = pc_val_i;
      end
   end

   assign data_o = w_hit[1] ? wr_data_i[W +: W] :
                   w_hit[0] ? wr_data_i[0 +: W] : w_base;
   assign busy_o = w_writable && gpr_busy_i && (w_hit == 2'b00);

endmodule

`default_nettype wire

// File: rtl/zmips_regfile_mp.sv
// zmips_regfile_mp: multi-port register file with two prioritised write lanes, PC capture
// and a per-register busy scoreboard.
`default_nettype none

module zmips_regfile_mp
   import zmips_pkg::*;
#(
   parameter int W       = ZMIPS_XLEN,
   parameter int NREGS   = ZMIPS_NREGS,
   parameter int NRD     = 2,
   parameter bit BYPASS  = 1'b1,
   parameter bit ZERO_R0 = 1'b0,
   localparam int AW     = $clog2(NREGS + 2)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD*W-1:0]  rd_data,
   output logic [NRD-1:0]    rd_busy,
   input  logic [1:0]        wr_en,
   input  logic [2*AW-1:0]   wr_addr,
   input  logic [2*W-1:0]    wr_data,
   input  logic              res_en,
   input  logic [AW-1:0]     res_addr,
   input  logic [W-1:0]      pc_val,
   input  logic              pc_wr
);

   logic [W-1:0]     gpr_q [NREGS];
   logic [W-1:0]     gpr_d [NREGS];
   logic [NREGS-1:0] busy_q, busy_d;
   logic [W-1:0]     pc_q, pc_d;

   // Lane 1 is applied after lane 0 so it wins on a shared address; a reservation is applied
   // last so a new producer keeps the register busy even while an older result retires.
   always_comb begin
      gpr_d  = gpr_q;
      busy_d = busy_q;
      pc_d   = pc_wr ? pc_val : pc_q;
      for (int j = 0; j < 2; j++) begin
         if (wr_en[j] && zmips_gpr_writable(32'(wr_addr[j*AW +: AW]), NREGS, ZERO_R0)) begin
            for (int r = 0; r < NREGS; r++) begin
               if (wr_addr[j*AW +: AW] == AW'(r)) begin
                  gpr_d[r]  = wr_data[j*W +: W];
                  busy_d[r] = 1'b0;
               end
            end
         end
      end
      if (res_en && zmips_gpr_writable(32'(res_addr), NREGS, ZERO_R0)) begin
         for (int r = 0; r < NREGS; r++) begin
            if (res_addr == AW'(r)) begin
               busy_d[r] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         gpr_q  <= '{default: '0};
         busy_q <= '0;
         pc_q   <= '0;
      end else begin
         gpr_q  <= gpr_d;
         busy_q <= busy_d;
         pc_q   <= pc_d;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic [W-1:0]  w_gpr;
      logic          w_busy;

      assign w_addr = rd_addr[i*AW +: AW];

      always_comb begin
         w_gpr  = '0;
         w_busy = 1'b0;
         for (int r = 0; r < NREGS; r++) begin
            if (w_addr == AW'(r)) begin
               w_gpr  = gpr_q[r];
               w_busy = busy_q[r];
            end
         end
      end

      zmips_regfile_rdport #(
         .W       (W),
         .NREGS   (NREGS),
         .AW      (AW),
         .BYPASS  (BYPASS),
         .ZERO_R0 (ZERO_R0)
      ) u_rdport (
         .addr_i     (w_addr),
         .gpr_data_i (w_gpr),
         .gpr_busy_i (w_busy),
         .pc_reg_i   (pc_q),
         .pc_val_i   (pc_val),
         .pc_wr_i    (pc_wr),
         .wr_en_i    (wr_en),
         .wr_addr_i  (wr_addr),
         .wr_data_i  (wr_data),
         .data_o     (rd_data[i*W +: W]),
         .busy_o     (rd_busy[i])
      );
   end

endmodule

`default_nettype wire

// File: tb/tb_zmips_regfile_mp.sv
// tb_zmips_regfile_mp: three register-file configurations against an array-based reference
// model; expectations are queued by the driver and checked by an independent monitor.
`default_nettype none

module tb_zmips_regfile_mp;

   localparam int AW1 = 5;
   localparam int AW2 = 4;
   localparam int N1  = 30;
   localparam int N2  = 14;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // System 1: default geometry, shared by a BYPASS=1 (A) and a BYPASS=0 (B) instance.
   logic [2*AW1-1:0] rd_addr1;
   logic [63:0]      rd_dataA, rd_dataB;
   logic [1:0]       rd_busyA, rd_busyB;
   logic [1:0]       wr_en1;
   logic [2*AW1-1:0] wr_addr1;
   logic [63:0]      wr_data1;
   logic             res_en1;
   logic [AW1-1:0]   res_addr1;
   logic [31:0]      pc_val1;
   logic             pc_wr1;

   // System 2: NREGS=14, NRD=4, ZERO_R0=1.
   logic [4*AW2-1:0] rd_addr2;
   logic [127:0]     rd_dataC;
   logic [3:0]       rd_busyC;
   logic [1:0]       wr_en2;
   logic [2*AW2-1:0] wr_addr2;
   logic [63:0]      wr_data2;
   logic             res_en2;
   logic [AW2-1:0]   res_addr2;
   logic [31:0]      pc_val2;
   logic             pc_wr2;

   zmips_regfile_mp #(.BYPASS(1'b1)) u_a (
      .clk(clk), .rst(rst), .rd_addr(rd_addr1), .rd_data(rd_dataA), .rd_busy(rd_busyA),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .res_en(res_en1),
      .res_addr(res_addr1), .pc_val(pc_val1), .pc_wr(pc_wr1));

   zmips_regfile_mp #(.BYPASS(1'b0)) u_b (
      .clk(clk), .rst(rst), .rd_addr(rd_addr1), .rd_data(rd_dataB), .rd_busy(rd_busyB),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .res_en(res_en1),
      .res_addr(res_addr1), .pc_val(pc_val1), .pc_wr(pc_wr1));

   zmips_regfile_mp #(.NREGS(N2), .NRD(4), .BYPASS(1'b1), .ZERO_R0(1'b1)) u_c (
      .clk(clk), .rst(rst), .rd_addr(rd_addr2), .rd_data(rd_dataC), .rd_busy(rd_busyC),
      .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .res_en(res_en2),
      .res_addr(res_addr2), .pc_val(pc_val2), .pc_wr(pc_wr2));

   // Reference state: index 0 = system 1, index 1 = system 2.
   logic [31:0] m_reg  [2][32];
   bit          m_busy [2][32];
   logic [31:0] m_pc   [2];

   typedef struct {
      int          dut;
      int          port;
      logic [31:0] d;
      bit          b;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   chk     = 1'b0;

   function automatic bit writable(int n, bit zr, int a);
      return (a < n) && !(zr && a == 0);
   endfunction

   function automatic int ra(int s, int p);
      return s ? int'(rd_addr2[p*AW2 +: AW2]) : int'(rd_addr1[p*AW1 +: AW1]);
   endfunction
   function automatic int wa(int s, int j);
      return s ? int'(wr_addr2[j*AW2 +: AW2]) : int'(wr_addr1[j*AW1 +: AW1]);
   endfunction
   function automatic bit we(int s, int j);
      return s ? wr_en2[j] : wr_en1[j];
   endfunction
   function automatic logic [31:0] wd(int s, int j);
      return s ? wr_data2[j*32 +: 32] : wr_data1[j*32 +: 32];
   endfunction
   function automatic logic [31:0] pcv(int s);
      return s ? pc_val2 : pc_val1;
   endfunction
   function automatic bit pcw(int s);
      return s ? pc_wr2 : pc_wr1;
   endfunction

   function automatic exp_t ref_read(int s, int dut, int p, bit byp);
      int   n  = s ? N2 : N1;
      bit   zr = (s == 1);
      int   a  = ra(s, p);
      exp_t e;
      e.dut = dut; e.port = p; e.d = '0; e.b = 1'b0;
      if (a < n) begin
         if (writable(n, zr, a)) begin
            e.d = m_reg[s][a];
            e.b = m_busy[s][a];
         end
      end else if (a == n) begin
         e.d = (byp && pcw(s)) ? pcv(s) : m_pc[s];
      end else if (a == n + 1) begin
         e.d = pcv(s);
      end
      if (byp && writable(n, zr, a)) begin
         for (int j = 0; j < 2; j++) begin
            if (we(s, j) && wa(s, j) == a) begin
               e.d = wd(s, j);
               e.b = 1'b0;
            end
         end
      end
      return e;
   endfunction

   task automatic model_step(int s);
      int n  = s ? N2 : N1;
      bit zr = (s == 1);
      int r  = s ? int'(res_addr2) : int'(res_addr1);
      bit re = s ? res_en2 : res_en1;
      if (rst) begin
         for (int a = 0; a < 32; a++) begin
            m_reg[s][a]  = '0;
            m_busy[s][a] = 1'b0;
         end
         m_pc[s] = '0;
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (we(s, j) && writable(n, zr, wa(s, j))) begin
               m_reg[s][wa(s, j)]  = wd(s, j);
               m_busy[s][wa(s, j)] = 1'b0;
            end
         end
         if (re && writable(n, zr, r)) m_busy[s][r] = 1'b1;
         if (pcw(s)) m_pc[s] = pcv(s);
      end
   endtask

   // Called just after a falling edge with inputs already set; returns at the next falling edge.
   task automatic apply();
      if (chk) begin
         for (int p = 0; p < 2; p++) begin
            q.push_back(ref_read(0, 0, p, 1'b1));
            q.push_back(ref_read(0, 1, p, 1'b0));
         end
         for (int p = 0; p < 4; p++) q.push_back(ref_read(1, 2, p, 1'b1));
      end
      model_step(0);
      model_step(1);
      @(negedge clk);
   endtask

   task automatic idle();
      rst = 1'b0;
      wr_en1 = '0; res_en1 = 1'b0; pc_wr1 = 1'b0;
      wr_en2 = '0; res_en2 = 1'b0; pc_wr2 = 1'b0;
   endtask

   task automatic rd1(int a0, int a1);
      rd_addr1 = {AW1'(a1), AW1'(a0)};
   endtask

   task automatic rd2(int a0, int a1, int a2, int a3);
      rd_addr2 = {AW2'(a3), AW2'(a2), AW2'(a1), AW2'(a0)};
   endtask

   function automatic int pick1();
      return ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 9));
   endfunction
   function automatic int pick2();
      return ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
   endfunction

   // Monitor: reads combinational outputs mid-low-phase, well before the next rising edge.
   initial begin
      exp_t        e;
      logic [31:0] ad;
      logic        ab;
      forever begin
         @(negedge clk);
         #3;
         while (q.size() > 0) begin
            e = q.pop_front();
            case (e.dut)
               0:       begin ad = rd_dataA[e.port*32 +: 32]; ab = rd_busyA[e.port]; end
               1:       begin ad = rd_dataB[e.port*32 +: 32]; ab = rd_busyB[e.port]; end
               default: begin ad = rd_dataC[e.port*32 +: 32]; ab = rd_busyC[e.port]; end
            endcase
            n_tests++;
            if (ad !== e.d || ab !== e.b) begin
               n_fail++;
               $display("FAIL dut%0d.port%0d @%0t: got data=%h busy=%b, expected data=%h busy=%b",
                        e.dut, e.port, $time, ad, ab, e.d, e.b);
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      rd_addr1 = '0; wr_en1 = '0; wr_addr1 = '0; wr_data1 = '0; res_en1 = 1'b0;
      res_addr1 = '0; pc_val1 = 32'hDEAD_BEEF; pc_wr1 = 1'b0;
      rd_addr2 = '0; wr_en2 = '0; wr_addr2 = '0; wr_data2 = '0; res_en2 = 1'b0;
      res_addr2 = '0; pc_val2 = 32'hDEAD_BEEF; pc_wr2 = 1'b0;
      @(negedge clk);
      chk = 1'b0;
      apply();
      chk = 1'b1;
      apply();

      // Post-reset sweep of every address.
      idle();
      for (int a = 0; a < 32; a += 2) begin
         rd1(a, a + 1);
         rd2(a % 16, (a + 1) % 16, (a + 2) % 16, (a + 3) % 16);
         apply();
      end

      // Both lanes to r5: lane 1 wins, visible same cycle through the bypass.
      idle();
      wr_en1 = 2'b11; wr_addr1 = {5'd5, 5'd5}; wr_data1 = {32'h2222, 32'h1111};
      rd1(5, 5); apply();
      idle(); rd1(5, 6); apply();

      // Lane write to PCR is ignored; pc_wr captures pc_val; PCL follows pc_val live.
      wr_en1 = 2'b01; wr_addr1 = {5'd0, 5'd30}; wr_data1 = {32'h0, 32'h55};
      rd1(30, 31); apply();
      idle(); pc_wr1 = 1'b1; pc_val1 = 32'h400; apply();
      idle(); pc_val1 = 32'h999; apply();

      // Reserve r7, then retire it.
      res_en1 = 1'b1; res_addr1 = 5'd7; rd1(7, 7); apply();
      idle(); apply();
      wr_en1 = 2'b01; wr_addr1 = {5'd0, 5'd7}; wr_data1 = {32'h0, 32'h77}; apply();
      idle(); apply();

      // Reserve and retire r9 together: stays busy, data updates.
      res_en1 = 1'b1; res_addr1 = 5'd9;
      wr_en1 = 2'b10; wr_addr1 = {5'd9, 5'd0}; wr_data1 = {32'h99, 32'h0};
      rd1(9, 9); apply();
      idle(); apply();

      // Reset dominates active writes.
      rst = 1'b1; wr_en1 = 2'b11; wr_addr1 = {5'd3, 5'd4}; wr_data1 = {32'hAAAA, 32'hBBBB};
      wr_en2 = 2'b11; wr_addr2 = {4'd3, 4'd4}; wr_data2 = {32'hCCCC, 32'hDDDD};
      rd1(3, 4); rd2(3, 4, 14, 15); apply();
      idle(); apply();

      // Hard-wired r0: writes and reservations are ignored.
      wr_en2 = 2'b01; wr_addr2 = {4'd0, 4'd0}; wr_data2 = {32'h0, 32'hFF};
      res_en2 = 1'b1; res_addr2 = 4'd0;
      rd2(0, 14, 15, 1); apply();
      idle(); pc_val2 = 32'h1234; rd2(0, 15, 14, 0); apply();

      // Randomised traffic on both systems.
      for (int it = 0; it < 400; it++) begin
         rst       = ($urandom_range(0, 63) == 0);
         wr_en1    = 2'($urandom);
         wr_addr1  = {AW1'(pick1()), AW1'(pick1())};
         wr_data1  = {$urandom, $urandom};
         res_en1   = ($urandom_range(0, 2) == 0);
         res_addr1 = AW1'(pick1());
         pc_wr1    = ($urandom_range(0, 3) == 0);
         pc_val1   = $urandom;
         rd1(pick1(), ($urandom_range(0, 2) == 0) ? int'(wr_addr1[AW1 +: AW1]) : pick1());
         wr_en2    = 2'($urandom);
         wr_addr2  = {AW2'(pick2()), AW2'(pick2())};
         wr_data2  = {$urandom, $urandom};
         res_en2   = ($urandom_range(0, 2) == 0);
         res_addr2 = AW2'(pick2());
         pc_wr2    = ($urandom_range(0, 3) == 0);
         pc_val2   = $urandom;
         rd2(pick2(), pick2(), int'(wr_addr2[0 +: AW2]), int'($urandom_range(0, 15)));
         apply();
      end

      idle();
      apply();
      #5;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
